move_controller: RTL
====================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter: CELL_PITCH, 29, pixel pitch between board cells.
REQ-002 SHALL have parameter: CNT_W, 16, move counter width.
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  in  1  load initial board and begin or restart a game.
REQ-006 SHALL have port: blank_init  in  4  0-based cell index of the blank in the initial board.
REQ-007 SHALL have port: dir_valid  in  1  direction request valid.
REQ-008 SHALL have port: dir  in  2  tile slide direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 SHALL have port: dir_ready  out  1  controller accepts a direction this cycle.
REQ-010 SHALL have port: load_board  out  1  one-cycle pulse; datapath loads its initial board.
REQ-011 SHALL have port: move_en  out  1  one-cycle pulse; datapath applies the move.
REQ-012 SHALL have port: move_from / move_to  out  5 each  1-based cell numbers 1..16 of the latched move.
REQ-013 SHALL have port: cell_value  in  4  datapath value at move_to.
REQ-014 SHALL have port: draw_req / draw_x / draw_y / draw_num  out  1/8/7/4  cell redraw request, cell origin, glyph (0 = blank).
REQ-015 SHALL have port: draw_done  in  1  drawer finished the current cell.
REQ-016 SHALL have port: if_win  in  1  datapath win flag.
REQ-017 SHALL have port: win / illegal / busy  out  1 each  sticky win; one-cycle rejected-move pulse; busy = state not IDLE, WAIT_DIR or WON.
REQ-018 SHALL have port: move_count  out  CNT_W  accepted moves since last load.

Function
REQ-019 SHALL implement the states IDLE, LOAD, WAIT_DIR, MOVE, DRAW_BLANK, DRAW_NUM, CHECK and WON.
REQ-020 SHALL track blank index b (0..15), with row = b/4 and col = b%4.
REQ-021 SHALL transition IDLE -> LOAD on start.
REQ-022 SHALL, in LOAD: load_board=1 for one cycle; b <= blank_init; move_count <= 0; win <= 0; next state WAIT_DIR.
REQ-023 SHALL, in WAIT_DIR: dir_ready=1; a request is accepted when dir_valid && dir_ready.
REQ-024 SHALL compute the source cell s = b+4 (up, illegal if row=3), b-4 (down, illegal if row=0), b+1 (left, illegal if col=3), b-1 (right, illegal if col=0).
REQ-025 SHALL, on a legal request: latch move_to <= b+1 and move_from <= s+1, then go to MOVE.
REQ-026 SHALL, on an illegal request: pulse illegal for exactly one cycle on the next cycle, stay in WAIT_DIR, leave b, move_count and outputs unchanged.
REQ-027 SHALL, in MOVE: move_en=1 for one cycle; b <= s; move_count increments, saturating at all-ones; next state DRAW_BLANK.
REQ-028 SHALL, in DRAW_BLANK: draw_req=1, draw_num=0, draw_x = ((move_from-1)%4)*CELL_PITCH, draw_y = ((move_from-1)/4)*CELL_PITCH; hold until draw_done, then go to DRAW_NUM.
REQ-029 SHALL, in DRAW_NUM: draw_req=1, draw_num=cell_value, coordinates from move_to; on draw_done go to CHECK.
REQ-030 SHALL honour draw_done in the first cycle of a draw state and ignore it in all other states.
REQ-031 SHALL keep draw_x, draw_y and draw_num stable while draw_req=1.
REQ-032 SHALL, in CHECK (one cycle): go to WON with win <= 1 if if_win, else go to WAIT_DIR.
REQ-033 SHALL, in WON: dir_ready=0, win held at 1, dir_valid ignored; start -> LOAD.
REQ-034 SHALL honour start only in IDLE, WAIT_DIR and WON, and ignore it in LOAD, MOVE, DRAW_BLANK, DRAW_NUM and CHECK.
REQ-035 SHALL give start priority over a simultaneous dir_valid in WAIT_DIR: no move is performed.
REQ-036 SHALL produce the move_en pulse exactly 1 cycle after acceptance, and exactly one move_en per accepted request.
REQ-037 SHALL hold move_from and move_to stable from acceptance until the next acceptance.

Reset
REQ-038 SHALL, on reset=1 at a clock edge: state IDLE; b=0; move_from=move_to=0; move_count=0; win=0; and all of dir_ready, load_board, move_en, draw_req, illegal, busy = 0; draw_x=draw_y=draw_num=0.
REQ-039 SHALL give reset precedence over every other input, including mid-draw, abandoning the draw with no further draw_req.

Verification
REQ-040 SHALL be verified by: reset; start with blank_init=15 -> load_board pulse 1 cycle, then dir_ready=1, move_count=0.
REQ-041 SHALL be verified by: b=15, dir=down -> move_to=16, move_from=12, move_en pulse; DRAW_BLANK x=87,y=58,num=0; DRAW_NUM x=87,y=87,num=cell_value; move_count=1.
REQ-042 SHALL be verified by: b=15, dir=up and dir=left -> illegal pulse each, no move_en, move_count unchanged.
REQ-043 SHALL be verified by: draw_done held low 20 cycles in DRAW_BLANK -> draw_req and coordinates stable, busy=1, dir_ready=0; draw_done in the first draw cycle -> accepted.
REQ-044 SHALL be verified by: if_win=1 at CHECK -> win=1, dir_ready=0, dir_valid ignored; start -> LOAD, win=0, move_count=0.
REQ-045 SHALL be verified by: reset asserted during DRAW_NUM -> next cycle all outputs at reset values; start during DRAW_BLANK -> ignored.

Source files
------------

// File: rtl/move_controller.sv
// Move controller for a 4x4 sliding-tile puzzle: tracks the blank cell, validates
// direction requests, and sequences the datapath move plus the two cell redraws.
module move_controller #(
    parameter int CELL_PITCH = 29,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       blank_init,
    input  logic             dir_valid,
    input  logic [1:0]       dir,
    output logic             dir_ready,
    output logic             load_board,
    output logic             move_en,
    output logic [4:0]       move_from,
    output logic [4:0]       move_to,
    input  logic [3:0]       cell_value,
    output logic             draw_req,
    output logic [7:0]       draw_x,
    output logic [6:0]       draw_y,
    output logic [3:0]       draw_num,
    input  logic             draw_done,
    input  logic             if_win,
    output logic             win,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] move_count
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD       = 3'd1;
    localparam logic [2:0] WAIT_DIR   = 3'd2;
    localparam logic [2:0] MOVE       = 3'd3;
    localparam logic [2:0] DRAW_BLANK = 3'd4;
    localparam logic [2:0] DRAW_NUM   = 3'd5;
    localparam logic [2:0] CHECK      = 3'd6;
    localparam logic [2:0] WON        = 3'd7;

    logic [2:0] state;
    logic [3:0] blankIdx;
    logic [3:0] srcIdx;
    logic       srcLegal;
    logic [3:0] drawIdx;

    // The source cell is the tile that slides into the blank, so "up" pulls from below.
    always_comb begin
        srcIdx   = blankIdx;
        srcLegal = 1'b0;
        case (dir)
            2'b00: begin
                srcIdx   = blankIdx + 4'd4;
                srcLegal = (blankIdx[3:2] != 2'd3);
            end
            2'b01: begin
                srcIdx   = blankIdx - 4'd4;
                srcLegal = (blankIdx[3:2] != 2'd0);
            end
            2'b10: begin
                srcIdx   = blankIdx + 4'd1;
                srcLegal = (blankIdx[1:0] != 2'd3);
            end
            default: begin
                srcIdx   = blankIdx - 4'd1;
                srcLegal = (blankIdx[1:0] != 2'd0);
            end
        endcase
    end

    always_comb begin
        drawIdx = 4'(move_to - 5'd1);
        if (state == DRAW_BLANK) begin
            drawIdx = 4'(move_from - 5'd1);
        end
    end

    assign dir_ready  = (state == WAIT_DIR);
    assign load_board = (state == LOAD);
    assign move_en    = (state == MOVE);
    assign draw_req   = (state == DRAW_BLANK) || (state == DRAW_NUM);
    assign busy       = !((state == IDLE) || (state == WAIT_DIR) || (state == WON));
    assign draw_x     = draw_req ? 8'(32'(drawIdx[1:0]) * CELL_PITCH) : 8'd0;
    assign draw_y     = draw_req ? 7'(32'(drawIdx[3:2]) * CELL_PITCH) : 7'd0;
    assign draw_num   = (state == DRAW_NUM) ? cell_value : 4'd0;

    // move_from/move_to are 1-based and stay put until the next accepted move,
    // so MOVE recovers the new blank position from move_from.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            blankIdx   <= 4'd0;
            move_from  <= 5'd0;
            move_to    <= 5'd0;
            move_count <= '0;
            win        <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    blankIdx   <= blank_init;
                    move_count <= '0;
                    win        <= 1'b0;
                    state      <= WAIT_DIR;
                end
                WAIT_DIR: begin
                    if (start) begin
                        state <= LOAD;
                    end else if (dir_valid) begin
                        if (srcLegal) begin
                            move_to   <= {1'b0, blankIdx} + 5'd1;
                            move_from <= {1'b0, srcIdx} + 5'd1;
                            state     <= MOVE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    blankIdx <= 4'(move_from - 5'd1);
                    if (move_count != '1) move_count <= move_count + CNT_W'(1);
                    state <= DRAW_BLANK;
                end
                DRAW_BLANK: begin
                    if (draw_done) state <= DRAW_NUM;
                end
                DRAW_NUM: begin
                    if (draw_done) state <= CHECK;
                end
                CHECK: begin
                    if (if_win) begin
                        win   <= 1'b1;
                        state <= WON;
                    end else begin
                        state <= WAIT_DIR;
                    end
                end
                WON: begin
                    if (start) state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
